fd_select_pipe: RTL and testbench

- Pipelined, parametrised final-quotient selection stage for the multiplicative (Newton/Goldschmidt) divider.
- Takes a dividend, a divisor, an approximate quotient E carrying G guard bits, and the precomputed product Eb = Db*E.
- Forms the back-multiplied remainder sign and zero test, then selects truncated E or E+ulp, with a sticky bit, for double or single precision.
- Generalises the combinational selector:
  - parametrised widths and single-precision alignment;
  - two-stage registered datapath with valid/ready backpressure;
  - tag passthrough and exported status flags.

---
 rtl/fd_select_pipe.sv | 152 +++++++++++++++
 tb/tb_fd_select_pipe.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fd_select_pipe.sv
// Final quotient selection for the multiplicative divider: stage 1 reduces
// the back-multiply to carry-save form, stage 2 resolves sign/zero and rounds.
module fd_select_pipe #(
    parameter int N     = 58,
    parameter int G     = 3,
    parameter int S     = 29,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_da,
    input  logic [N-1:0]     in_db,
    input  logic [2*N-2:0]   in_eb,
    input  logic [N-1:0]     in_e,
    input  logic             in_dbl,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-G+1:0]   out_fd,
    output logic             out_neg,
    output logic             out_exact,
    output logic [TAG_W-1:0] out_tag
);
    localparam int W  = 2 * N;
    localparam int RW = N - G + 1;
    localparam int EW = N - G;

    logic [N+S-1:0]   x;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [W-1:0]     op_c;
    logic [W:0]       cs_s;
    logic [W:0]       cs_c;

    logic             s1_valid_d, s1_valid_q;
    logic [W:0]       s1_sum_d, s1_sum_q;
    logic [W:0]       s1_car_d, s1_car_q;
    logic [EW-1:0]    s1_eh_d, s1_eh_q;
    logic             s1_dbl_d, s1_dbl_q;
    logic [TAG_W-1:0] s1_tag_d, s1_tag_q;

    logic             out_valid_d, out_valid_q;
    logic [RW:0]      out_fd_d, out_fd_q;
    logic             out_neg_d, out_neg_q;
    logic             out_exact_d, out_exact_q;
    logic [TAG_W-1:0] out_tag_d, out_tag_q;

    logic [W+1:0]     sum;
    logic             neg;
    logic             zero;
    logic [RW-1:0]    r;
    logic [RW:0]      fd;
    logic             s1_adv;
    logic             accept;

    // 3:2 compression of a + b + c; the +1 is folded into stage 2's carry-in
    always_comb begin
        x    = in_dbl ? {{S{1'b0}}, in_db} : {in_db, {S{1'b0}}};
        op_a = {1'b0, in_da, {(N-2){1'b0}}, 1'b1};
        op_b = {1'b1, ~in_eb};
        op_c = {{(N-S-G){1'b1}}, ~x, {G{1'b1}}};
        cs_s = {1'b0, op_a ^ op_b ^ op_c};
        cs_c = {(op_a & op_b) | (op_a & op_c) | (op_b & op_c), 1'b0};
    end

    always_comb begin
        sum  = {1'b0, s1_sum_q} + {1'b0, s1_car_q}
             + {{(W+1){1'b0}}, 1'b1};
        neg  = sum[W+1];
        zero = ~|sum[W:0];
        if (neg) begin
            r = {1'b0, s1_eh_q};
        end else if (s1_dbl_q) begin
            r = {1'b0, s1_eh_q} + {{(RW-1){1'b0}}, 1'b1};
        end else begin
            r = {1'b0, s1_eh_q[EW-1:S], {S{1'b1}}}
              + {{(RW-1){1'b0}}, 1'b1};
        end
        fd = {r, s1_dbl_q & ~zero};
        if (!s1_dbl_q) begin
            fd[S] = ~zero;
        end
    end

    always_comb begin
        s1_adv   = !out_valid_q | out_ready;
        in_ready = !rst & (!s1_valid_q | s1_adv);
        accept   = in_valid & in_ready;

        s1_valid_d  = accept | (s1_valid_q & !s1_adv);
        s1_sum_d    = s1_sum_q;
        s1_car_d    = s1_car_q;
        s1_eh_d     = s1_eh_q;
        s1_dbl_d    = s1_dbl_q;
        s1_tag_d    = s1_tag_q;
        out_valid_d = s1_adv ? s1_valid_q : out_valid_q;
        out_fd_d    = out_fd_q;
        out_neg_d   = out_neg_q;
        out_exact_d = out_exact_q;
        out_tag_d   = out_tag_q;

        if (accept) begin
            s1_sum_d = cs_s;
            s1_car_d = cs_c;
            s1_eh_d  = in_e[N-1:G];
            s1_dbl_d = in_dbl;
            s1_tag_d = in_tag;
        end
        if (s1_adv && s1_valid_q) begin
            out_fd_d    = fd;
            out_neg_d   = neg;
            out_exact_d = zero;
            out_tag_d   = s1_tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_car_q    <= '0;
            s1_eh_q     <= '0;
            s1_dbl_q    <= 1'b0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_fd_q    <= '0;
            out_neg_q   <= 1'b0;
            out_exact_q <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_car_q    <= s1_car_d;
            s1_eh_q     <= s1_eh_d;
            s1_dbl_q    <= s1_dbl_d;
            s1_tag_q    <= s1_tag_d;
            out_valid_q <= out_valid_d;
            out_fd_q    <= out_fd_d;
            out_neg_q   <= out_neg_d;
            out_exact_q <= out_exact_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_fd    = out_fd_q;
    assign out_neg   = out_neg_q;
    assign out_exact = out_exact_q;
    assign out_tag   = out_tag_q;
endmodule

// File: tb/tb_fd_select_pipe.sv
// Directed and randomised bench for fd_select_pipe with a reference
// model of the back-multiply sign/zero test and quotient selection.
module tb_fd_select_pipe;
    localparam int N = 58;
    localparam int G = 3;
    localparam int S = 29;
    localparam int TW = 4;
    localparam logic [57:0] E0 = 58'd1 << 57;
    localparam logic [57:0] D0 = 58'd1 << 56;
    localparam logic [56:0] P55 = 57'd1 << 55;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [N-1:0] in_da = '0;
    logic [N-1:0] in_db = '0;
    logic [2*N-2:0] in_eb = '0;
    logic [N-1:0] in_e = '0;
    logic in_dbl = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [N-G+1:0] out_fd;
    logic out_neg;
    logic out_exact;
    logic [TW-1:0] out_tag;

    fd_select_pipe #(.N(N), .G(G), .S(S), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_da(in_da), .in_db(in_db), .in_eb(in_eb), .in_e(in_e),
        .in_dbl(in_dbl), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_fd(out_fd), .out_neg(out_neg), .out_exact(out_exact),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic acc, drn, o_valid, o_irdy, o_neg, o_exact;
    logic [56:0] o_fd;
    logic [3:0] o_tag;
    logic [62:0] q[$];

    function automatic logic [58:0] model(input logic [57:0] da,
        input logic [57:0] db, input logic [57:0] e,
        input logic [114:0] eb, input logic dbl);
        logic [115:0] a, b, c;
        logic [86:0] x;
        logic [117:0] sm;
        logic ng, zr;
        logic [54:0] eh;
        logic [55:0] r;
        logic [56:0] fd;
        a = {1'b0, da, 56'd0, 1'b1};
        b = {1'b1, ~eb};
        x = dbl ? {29'd0, db} : {db, 29'd0};
        c = {26'h3ffffff, ~x, 3'b111};
        sm = {2'b0, a} + {2'b0, b} + {2'b0, c} + 118'd1;
        ng = sm[117];
        zr = (sm[116:0] == 117'd0);
        eh = e[57:3];
        if (ng) r = {1'b0, eh};
        else if (dbl) r = {1'b0, eh} + 56'd1;
        else r = {1'b0, eh[54:29], 29'h1fffffff} + 56'd1;
        fd = {r, dbl & ~zr};
        if (!dbl) fd[29] = ~zr;
        return {ng, zr, fd};
    endfunction

    task automatic cyc(input logic iv, input logic ordy);
        @(negedge clk);
        in_valid = iv;
        out_ready = ordy;
        #1;
        acc = in_valid & in_ready;
        drn = out_valid & out_ready;
        o_valid = out_valid;
        o_irdy = in_ready;
        o_fd = out_fd;
        o_neg = out_neg;
        o_exact = out_exact;
        o_tag = out_tag;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [57:0] e, input logic dbl,
        input logic [3:0] tag);
        in_da = D0;
        in_db = D0;
        in_e = e;
        in_eb = 115'(e) << 56;
        in_dbl = dbl;
        in_tag = tag;
    endtask

    task automatic rand_op(input logic [3:0] tag);
        logic [57:0] db, e;
        logic dbl;
        dbl = 1'($urandom_range(1));
        db = 58'({$urandom(), $urandom()});
        e = 58'({$urandom(), $urandom()});
        if ($urandom_range(1) == 1) begin
            db[57:56] = 2'b01;
            if (dbl) e = E0 - 58'($urandom_range(16));
            else e = E0 - (58'($urandom_range(2)) << 32);
            in_da = db;
            in_eb = 115'({58'd0, db} * {58'd0, e});
        end else begin
            in_da = 58'({$urandom(), $urandom()});
            in_eb = 115'({$urandom(), $urandom(), $urandom(), $urandom()});
        end
        in_db = db;
        in_e = e;
        in_dbl = dbl;
        in_tag = tag;
    endtask

    task automatic run_one(output logic ok);
        int n;
        ok = 1'b0;
        n = 0;
        do begin cyc(1'b1, 1'b1); n++; end while (!acc && n < 10);
        if (!acc) return;
        n = 0;
        do begin cyc(1'b0, 1'b1); n++; end while (!drn && n < 10);
        ok = drn;
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b want=0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        checks++;
        if ({out_fd, out_neg, out_exact, out_tag} !== '0) begin
            failures++;
            $display("FAIL reset_outs fd=%h tag=%h want=0", out_fd, out_tag);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_golden_dbl();
        logic [57:0] ev[5];
        logic [56:0] fv[5];
        logic [4:0] nv, zv;
        logic ok;
        logic [58:0] m;
        ev[0] = E0;      fv[0] = P55 + 57'd3;
        ev[1] = E0 - 1;  fv[1] = P55 + 57'd1;
        ev[2] = E0 + 1;  fv[2] = P55 + 57'd3;
        ev[3] = E0 - 8;  fv[3] = P55 - 57'd2;
        ev[4] = E0 - 16; fv[4] = P55 - 57'd3;
        nv = 5'b11000;
        zv = 5'b01000;
        for (int i = 0; i < 5; i++) begin
            set_op(ev[i], 1'b1, 4'(i));
            m = model(in_da, in_db, in_e, in_eb, in_dbl);
            run_one(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL dbl_timeout vec=%0d got=none want=result", i);
                continue;
            end
            checks++;
            if (o_fd !== fv[i] || o_neg !== nv[i] || o_exact !== zv[i]) begin
                failures++;
                $display("FAIL dbl_hand vec=%0d got=%h/%b/%b want=%h/%b/%b",
                    i, o_fd, o_neg, o_exact, fv[i], nv[i], zv[i]);
            end
            checks++;
            if ({o_neg, o_exact, o_fd} !== m) begin
                failures++;
                $display("FAIL dbl_model vec=%0d got=%h want=%h",
                    i, {o_neg, o_exact, o_fd}, m);
            end
        end
    endtask

    task automatic test_single();
        logic [57:0] ev[3];
        logic [56:0] fv[3];
        logic [2:0] nv, zv;
        logic ok;
        logic [58:0] m;
        ev[0] = E0;
        fv[0] = P55 + (57'd1 << 30) + (57'd1 << 29);
        ev[1] = E0 - (58'd1 << 32);
        fv[1] = P55 - (57'd1 << 30);
        ev[2] = E0 - (58'd1 << 33);
        fv[2] = P55 - (57'd1 << 31) + (57'd1 << 29);
        nv = 3'b110;
        zv = 3'b010;
        for (int i = 0; i < 3; i++) begin
            set_op(ev[i], 1'b0, 4'(i + 8));
            m = model(in_da, in_db, in_e, in_eb, in_dbl);
            run_one(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL sgl_timeout vec=%0d got=none want=result", i);
                continue;
            end
            checks++;
            if (o_fd !== fv[i] || o_neg !== nv[i] || o_exact !== zv[i]) begin
                failures++;
                $display("FAIL sgl_hand vec=%0d got=%h/%b/%b want=%h/%b/%b",
                    i, o_fd, o_neg, o_exact, fv[i], nv[i], zv[i]);
            end
            checks++;
            if (o_fd[S] !== ~zv[i] || o_fd[0] !== 1'b0) begin
                failures++;
                $display("FAIL sgl_sticky vec=%0d got=%b%b want=%b0",
                    i, o_fd[S], o_fd[0], ~zv[i]);
            end
            if (!nv[i]) begin
                checks++;
                if (o_fd[S-1:1] !== '0) begin
                    failures++;
                    $display("FAIL sgl_low_zero vec=%0d got=%h want=0",
                        i, o_fd[S-1:1]);
                end
            end
            checks++;
            if ({o_neg, o_exact, o_fd} !== m) begin
                failures++;
                $display("FAIL sgl_model vec=%0d got=%h want=%h",
                    i, {o_neg, o_exact, o_fd}, m);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sent, got, cy, first_acc, first_drn, last;
        logic [62:0] ex;
        sent = 0; got = 0; cy = 0;
        first_acc = -1; first_drn = -1; last = -1;
        q.delete();
        rand_op(4'd0);
        while ((sent < 16 || got < 16) && cy < 100) begin
            cyc(sent < 16, 1'b1);
            if (drn) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL stream_extra got=tag%0h want=none", o_tag);
                end else begin
                    ex = q.pop_front();
                    if ({o_tag, o_neg, o_exact, o_fd} !== ex) begin
                        failures++;
                        $display("FAIL stream_data got=%h want=%h",
                            {o_tag, o_neg, o_exact, o_fd}, ex);
                    end
                end
                if (got == 0) first_drn = cy;
                else begin
                    checks++;
                    if (cy != last + 1) begin
                        failures++;
                        $display("FAIL stream_gap got=%0d want=%0d",
                            cy, last + 1);
                    end
                end
                last = cy;
                got++;
            end
            if (acc) begin
                q.push_back({in_tag,
                    model(in_da, in_db, in_e, in_eb, in_dbl)});
                if (sent == 0) first_acc = cy;
                sent++;
                rand_op(4'(sent));
            end
            cy++;
        end
        checks++;
        if (got != 16) begin
            failures++;
            $display("FAIL stream_count got=%0d want=16", got);
        end
        checks++;
        if (first_drn - first_acc != 2) begin
            failures++;
            $display("FAIL stream_latency got=%0d want=2",
                first_drn - first_acc);
        end
    endtask

    task automatic test_backpressure();
        int accepted, got, cy;
        logic [56:0] hold_fd;
        logic [3:0] hold_tag;
        logic [62:0] ex;
        accepted = 0; got = 0;
        hold_fd = '0; hold_tag = '0;
        q.delete();
        rand_op(4'd3);
        for (int i = 0; i < 5; i++) begin
            cyc(accepted < 3, 1'b0);
            if (acc) begin
                q.push_back({in_tag,
                    model(in_da, in_db, in_e, in_eb, in_dbl)});
                accepted++;
                rand_op(4'(accepted + 3));
            end
            if (i == 2) begin
                hold_fd = o_fd;
                hold_tag = o_tag;
            end
            if (i >= 2) begin
                checks++;
                if (o_irdy !== 1'b0 || o_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_full cyc=%0d got=rdy%b/vld%b want=0/1",
                        i, o_irdy, o_valid);
                end
            end
            if (i > 2) begin
                checks++;
                if (o_fd !== hold_fd || o_tag !== hold_tag) begin
                    failures++;
                    $display("FAIL bp_hold got=%h/%h want=%h/%h",
                        o_fd, o_tag, hold_fd, hold_tag);
                end
            end
        end
        checks++;
        if (accepted != 2) begin
            failures++;
            $display("FAIL bp_accepted got=%0d want=2", accepted);
        end
        cy = 0;
        while ((accepted < 3 || q.size() != 0) && cy < 20) begin
            cyc(accepted < 3, 1'b1);
            if (drn) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra got=tag%0h want=none", o_tag);
                end else begin
                    ex = q.pop_front();
                    if ({o_tag, o_neg, o_exact, o_fd} !== ex) begin
                        failures++;
                        $display("FAIL bp_drain got=%h want=%h",
                            {o_tag, o_neg, o_exact, o_fd}, ex);
                    end
                end
                got++;
            end
            if (acc) begin
                q.push_back({in_tag,
                    model(in_da, in_db, in_e, in_eb, in_dbl)});
                accepted++;
            end
            cy++;
        end
        checks++;
        if (got != 3) begin
            failures++;
            $display("FAIL bp_count got=%0d want=3", got);
        end
    endtask

    task automatic test_reset_midflight();
        int n, stale;
        n = 0; stale = 0;
        q.delete();
        rand_op(4'd1);
        cyc(1'b1, 1'b0);
        if (acc) n++;
        rand_op(4'd2);
        cyc(1'b1, 1'b0);
        if (acc) n++;
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL rst_accept got=%0d want=2", n);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_ready got=%b want=0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got=vld%b/rdy%b want=0/0",
                out_valid, in_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1);
            if (o_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL rst_stale got=%0d want=0", stale);
        end
    endtask

    task automatic test_random();
        int sent, got, cy;
        logic ordy, stall;
        logic [56:0] pfd;
        logic [3:0] ptag;
        logic [62:0] ex;
        sent = 0; got = 0; cy = 0;
        stall = 1'b0; pfd = '0; ptag = '0;
        q.delete();
        rand_op(4'd0);
        while ((sent < 10000 || got < 10000) && cy < 60000) begin
            ordy = ($urandom_range(3) != 0);
            cyc(sent < 10000 && $urandom_range(3) != 0, ordy);
            if (stall) begin
                checks++;
                if (!o_valid || o_fd !== pfd || o_tag !== ptag) begin
                    failures++;
                    $display("FAIL rnd_hold got=%b/%h/%h want=1/%h/%h",
                        o_valid, o_fd, o_tag, pfd, ptag);
                end
            end
            stall = o_valid & !ordy;
            pfd = o_fd;
            ptag = o_tag;
            if (drn) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_extra got=tag%0h want=none", o_tag);
                end else begin
                    ex = q.pop_front();
                    if ({o_tag, o_neg, o_exact, o_fd} !== ex) begin
                        failures++;
                        $display("FAIL rnd_data got=%h want=%h",
                            {o_tag, o_neg, o_exact, o_fd}, ex);
                    end
                end
                got++;
            end
            if (acc) begin
                q.push_back({in_tag,
                    model(in_da, in_db, in_e, in_eb, in_dbl)});
                sent++;
                rand_op(4'(sent));
            end
            cy++;
        end
        checks++;
        if (got != 10000 || q.size() != 0) begin
            failures++;
            $display("FAIL rnd_count got=%0d/%0d want=10000/0",
                got, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_golden_dbl();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
